nvdla_apb2csb: RTL and testbench

NVDLA_APB2CSB -- requirements
Module: nvdla_apb2csb

---
 rtl/nvdla_apb2csb.sv | 69 ++++++
 tb/tb_nvdla_apb2csb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_apb2csb.sv
// APB-to-CSB bridge for the NVDLA configuration space.
// APB accesses become single CSB requests. Writes are posted and
// complete on request acceptance. Reads complete on the CSB read
// response. One state bit, rd_pend, makes sure a read request is
// issued only once while its response is outstanding.
module nvdla_apb2csb (
    input  logic        pclk,
    input  logic        prstn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        csb2nvdla_valid,
    input  logic        csb2nvdla_ready,
    output logic [15:0] csb2nvdla_addr,
    output logic [31:0] csb2nvdla_wdat,
    output logic        csb2nvdla_write,
    output logic        csb2nvdla_nposted,
    input  logic        nvdla2csb_valid,
    input  logic [31:0] nvdla2csb_data
);

    // Access-phase qualifiers for the two transfer directions.
    logic wr_vld;
    logic rd_vld;

    // 0 = idle or request phase, 1 = read accepted and waiting for response.
    logic rd_pend;

    // The CSB address is a word address, so the byte-lane bits and the
    // upper APB address bits are dropped on purpose.
    logic unused_paddr_bits;

    assign wr_vld = psel & penable & pwrite;
    assign rd_vld = psel & penable & ~pwrite;

    assign unused_paddr_bits = ^{paddr[31:18], paddr[1:0]};

    // Track the outstanding read. A response in flight wins over a new
    // acceptance, and a response with no read pending is ignored.
    always_ff @(posedge pclk) begin
        if (prstn) begin
            rd_pend <= 1'b0;
        end else if (nvdla2csb_valid & rd_pend) begin
            rd_pend <= 1'b0;
        end else if (rd_vld & csb2nvdla_ready) begin
            rd_pend <= 1'b1;
        end else begin
            rd_pend <= rd_pend;
        end
    end

    // Request side. A write is presented for its whole access phase. A
    // read is withdrawn once it is accepted, so it is issued only once.
    assign csb2nvdla_valid   = wr_vld | (rd_vld & ~rd_pend);
    assign csb2nvdla_addr    = paddr[17:2];
    assign csb2nvdla_wdat    = pwdata;
    assign csb2nvdla_write   = pwrite;
    assign csb2nvdla_nposted = 1'b0;

    // Completion side. Read data passes straight through and is only
    // meaningful in the cycle pready is high during a read.
    assign prdata = nvdla2csb_data;
    assign pready = ~((wr_vld & ~csb2nvdla_ready) | (rd_vld & ~nvdla2csb_valid));

endmodule

// File: tb/tb_nvdla_apb2csb.sv
// Directed, self-checking bench for nvdla_apb2csb with a request/response scoreboard.
module tb_nvdla_apb2csb;

    logic        pclk = 1'b0;
    logic        prstn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        csb_valid;
    logic        csb_ready;
    logic [15:0] csb_addr;
    logic [31:0] csb_wdat;
    logic        csb_write;
    logic        csb_nposted;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] wdat;
        logic        write;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rsp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          accepts = 0;
    int          base;

    nvdla_apb2csb dut (
        .pclk              (pclk),
        .prstn             (prstn),
        .psel              (psel),
        .penable           (penable),
        .pwrite            (pwrite),
        .paddr             (paddr),
        .pwdata            (pwdata),
        .prdata            (prdata),
        .pready            (pready),
        .csb2nvdla_valid   (csb_valid),
        .csb2nvdla_ready   (csb_ready),
        .csb2nvdla_addr    (csb_addr),
        .csb2nvdla_wdat    (csb_wdat),
        .csb2nvdla_write   (csb_write),
        .csb2nvdla_nposted (csb_nposted),
        .nvdla2csb_valid   (rsp_valid),
        .nvdla2csb_data    (rsp_data)
    );

    // Free-running clock.
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare accepted CSB requests and completed reads.
    task automatic monitor();
        req_t r;
        chk("nposted", 32'(csb_nposted), 32'h0);
        if (csb_valid && csb_ready) begin
            accepts++;
            if (req_q.size() == 0) begin
                chk("unexpected_req", 32'h1, 32'h0);
            end else begin
                r = req_q.pop_front();
                chk("req_addr", 32'(csb_addr), 32'(r.addr));
                chk("req_write", 32'(csb_write), 32'(r.write));
                if (r.write) chk("req_wdat", csb_wdat, r.wdat);
            end
        end
        if (psel && penable && !pwrite && pready) begin
            if (rsp_q.size() == 0) chk("unexpected_rsp", 32'h1, 32'h0);
            else chk("prdata", prdata, rsp_q.pop_front());
        end
    endtask

    // Drive one cycle at the falling edge, then sample before the rising edge.
    task automatic drive(input logic s, input logic e, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic r, input logic v, input logic [31:0] rd,
                         input logic rst);
        @(negedge pclk);
        psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
        csb_ready = r; rsp_valid = v; rsp_data = rd; prstn = rst;
        #2;
        monitor();
    endtask

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        csb_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0; prstn = 1'b1;

        // Reset, then idle state.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_valid", 32'(csb_valid), 32'h0);
        chk("rst_pready", 32'(pready), 32'h1);

        // Write with two ready wait states.
        req_q.push_back('{addr: 16'h1402, wdat: 32'hDEADBEEF, write: 1'b1});
        drive(1'b1, 1'b0, 1'b1, 32'h0000_5008, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h0000_5008, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("wr_valid", 32'(csb_valid), 32'h1);
            chk("wr_pready_wait", 32'(pready), 32'h0);
            chk("wr_addr", 32'(csb_addr), 32'h1402);
            chk("wr_wdat", csb_wdat, 32'hDEADBEEF);
            chk("wr_write", 32'(csb_write), 32'h1);
        end
        drive(1'b1, 1'b1, 1'b1, 32'h0000_5008, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("wr_valid_last", 32'(csb_valid), 32'h1);
        chk("wr_pready_done", 32'(pready), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Read accepted at once, response three cycles later.
        req_q.push_back('{addr: 16'hFFFF, wdat: 32'h0, write: 1'b0});
        rsp_q.push_back(32'h12345678);
        drive(1'b1, 1'b0, 1'b0, 32'h0003_FFFC, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h0003_FFFC, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("rd_addr", 32'(csb_addr), 32'hFFFF);
        chk("rd_valid_first", 32'(csb_valid), 32'h1);
        chk("rd_pready_wait", 32'(pready), 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0003_FFFC, 32'h0, 1'b1, 1'b0, 32'hFFFF_0000, 1'b0);
            chk("rd_valid_dropped", 32'(csb_valid), 32'h0);
            chk("rd_pready_pend", 32'(pready), 32'h0);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0003_FFFC, 32'h0, 1'b1, 1'b1, 32'h12345678, 1'b0);
        chk("rd_pready_done", 32'(pready), 32'h1);
        chk("rd_valid_rsp", 32'(csb_valid), 32'h0);
        chk("rd_prdata", prdata, 32'h12345678);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Zero-wait read: acceptance and response in the same cycle.
        req_q.push_back('{addr: 16'h0123, wdat: 32'h0, write: 1'b0});
        rsp_q.push_back(32'hA5A5_0001);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_048C, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_048C, 32'h0, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0);
        chk("zw_pready", 32'(pready), 32'h1);
        chk("zw_valid", 32'(csb_valid), 32'h1);
        // The pending bit set by that read is cleared by a later response;
        // a further stray response with nothing pending is ignored.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("idle_rsp_pready", 32'(pready), 32'h1);

        // Back-to-back write, read, write.
        base = accepts;
        req_q.push_back('{addr: 16'h0040, wdat: 32'h1111_1111, write: 1'b1});
        req_q.push_back('{addr: 16'h0041, wdat: 32'h0, write: 1'b0});
        req_q.push_back('{addr: 16'h0042, wdat: 32'h3333_3333, write: 1'b1});
        rsp_q.push_back(32'h2222_2222);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_1111, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("b2b_rd_valid", 32'(csb_valid), 32'h1);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b1, 1'b1, 32'h2222_2222, 1'b0);
        chk("b2b_rd_done", 32'(pready), 32'h1);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0108, 32'h3333_3333, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0108, 32'h3333_3333, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("b2b_wr_done", 32'(pready), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("b2b_accepts", 32'(accepts - base), 32'h3);

        // Reset while a read is pending; the held read is reissued.
        req_q.push_back('{addr: 16'h0200, wdat: 32'h0, write: 1'b0});
        req_q.push_back('{addr: 16'h0200, wdat: 32'h0, write: 1'b0});
        rsp_q.push_back(32'h0BAD_CAFE);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0800, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("mr_pend_valid", 32'(csb_valid), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("mr_reissue_valid", 32'(csb_valid), 32'h1);
        chk("mr_pready_wait", 32'(pready), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 1'b1, 1'b1, 32'h0BAD_CAFE, 1'b0);
        chk("mr_pready_done", 32'(pready), 32'h1);

        // Idle with penable/pwrite toggling and psel low.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i[0], i[1], 32'h0000_0010, 32'h0, i[0], 1'b0, 32'h0, 1'b0);
            chk("idle_valid", 32'(csb_valid), 32'h0);
            chk("idle_pready", 32'(pready), 32'h1);
        end

        chk("req_q_empty", 32'(req_q.size()), 32'h0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
